adc_frame_fifo: RTL and testbench

ADC_FRAME_FIFO -- requirements
Module: adc_frame_fifo

---
 rtl/adc_pkg.sv | 21 ++
 rtl/adc_frame_fifo_if.sv | 33 +++
 rtl/adc_frame_ram.sv | 34 +++
 rtl/adc_frame_fifo.sv | 131 +++++++++++++
 tb/tb_adc_frame_fifo.sv | 211 +++++++++++++++++++++
 5 files changed

// File: rtl/adc_pkg.sv
// Shared ADC frame definitions, also used by the serial collector.
package adc_pkg;

  localparam int N_CH       = 4;
  localparam int SAMPLE_W   = 32;
  localparam int FIFO_DEPTH = 8;
  localparam int DROP_W     = 16;

  typedef logic [N_CH-1:0][SAMPLE_W-1:0] adc_frame_t;

  typedef enum logic {
    ST_EMPTY  = 1'b0,
    ST_STREAM = 1'b1
  } ofsm_e;

  // Index width that stays legal for a count of one.
  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/adc_frame_fifo_if.sv
// Frame-in / word-out bus of the ADC frame FIFO, plus its status and control.
interface adc_frame_fifo_if #(
  parameter int N_CH     = 4,
  parameter int SAMPLE_W = 32,
  parameter int DEPTH    = 8
);
  localparam int CH_W  = (N_CH > 1) ? $clog2(N_CH) : 1;
  localparam int LVL_W = $clog2(DEPTH) + 1;

  logic                           in_valid;
  logic [N_CH-1:0][SAMPLE_W-1:0]  in_frame;
  logic                           out_valid;
  logic                           out_ready;
  logic [SAMPLE_W-1:0]            out_data;
  logic [CH_W-1:0]                out_ch;
  logic                           out_last;
  logic [LVL_W-1:0]               level;
  logic                           overflow;
  logic [15:0]                    drop_cnt;
  logic                           clear_ovf;

  // FIFO side
  modport slave (
    input  in_valid, in_frame, out_ready, clear_ovf,
    output out_valid, out_data, out_ch, out_last, level, overflow, drop_cnt
  );

  // Producer / consumer side
  modport master (
    output in_valid, in_frame, out_ready, clear_ovf,
    input  out_valid, out_data, out_ch, out_last, level, overflow, drop_cnt
  );
endinterface

// File: rtl/adc_frame_ram.sv
// Frame store: one whole-frame write port, one async word read port.
// Each channel lives in its own bank so a frame lands in a single cycle.
module adc_frame_ram #(
  parameter int N_CH     = 4,
  parameter int SAMPLE_W = 32,
  parameter int DEPTH    = 8,
  parameter int AW       = $clog2(DEPTH),
  parameter int CH_W     = (N_CH > 1) ? $clog2(N_CH) : 1
) (
  input  logic                          clk,
  input  logic                          we,
  input  logic [AW-1:0]                 waddr,
  input  logic [N_CH-1:0][SAMPLE_W-1:0] wdata,
  input  logic [AW-1:0]                 raddr,
  input  logic [CH_W-1:0]               rch,
  output logic [SAMPLE_W-1:0]           rdata
);

  logic [N_CH-1:0][SAMPLE_W-1:0] rd_words;

  for (genvar c = 0; c < N_CH; c++) begin : g_bank
    logic [SAMPLE_W-1:0] mem [DEPTH];

    // Channel c of the incoming frame into its bank.
    always_ff @(posedge clk) begin
      if (we) mem[waddr] <= wdata[c];
    end

    assign rd_words[c] = mem[raddr];
  end

  assign rdata = rd_words[rch];

endmodule

// File: rtl/adc_frame_fifo.sv
// ADC frame FIFO: stores whole frames, streams them out one channel word
// per transfer. Frames arriving while full are dropped and counted unless
// the last word of the head frame leaves in the same cycle.
module adc_frame_fifo #(
  parameter int N_CH     = adc_pkg::N_CH,
  parameter int SAMPLE_W = adc_pkg::SAMPLE_W,
  parameter int DEPTH    = adc_pkg::FIFO_DEPTH
) (
  input  logic             clk,
  input  logic             rst,
  adc_frame_fifo_if.slave  bus
);
  import adc_pkg::*;

  localparam int AW    = $clog2(DEPTH);
  localparam int CH_W  = idx_w(N_CH);
  localparam int LVL_W = AW + 1;

  localparam logic [CH_W-1:0]   LAST_CH  = CH_W'(N_CH - 1);
  localparam logic [LVL_W-1:0]  FULL_LVL = LVL_W'(DEPTH);
  localparam logic [DROP_W-1:0] CNT_MAX  = '1;

  ofsm_e               state;
  logic [AW-1:0]       wr_ptr, rd_ptr;
  logic [LVL_W-1:0]    level, level_nxt;
  logic [CH_W-1:0]     out_ch;
  logic                out_valid, out_last;
  logic                overflow;
  logic [DROP_W-1:0]   drop_cnt;
  logic                pop, pop_last, wr_en, drop;

  // Handshake decode; a full FIFO still takes a frame if a slot frees this cycle.
  always_comb begin
    pop       = out_valid & bus.out_ready;
    pop_last  = pop & (out_ch == LAST_CH);
    wr_en     = bus.in_valid & ((level != FULL_LVL) | pop_last);
    drop      = bus.in_valid & ~wr_en;
    level_nxt = level + LVL_W'(wr_en) - LVL_W'(pop_last);
  end

  // Circular-buffer pointers and frame count.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (wr_en)    wr_ptr <= wr_ptr + 1'b1;
      if (pop_last) rd_ptr <= rd_ptr + 1'b1;
      level <= level_nxt;
    end
  end

  // Output FSM: walks the channels of the head frame, no gap between frames.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= ST_EMPTY;
      out_valid <= 1'b0;
      out_last  <= 1'b0;
      out_ch    <= '0;
    end else begin
      case (state)
        ST_EMPTY: begin
          if (level != '0) begin
            state     <= ST_STREAM;
            out_valid <= 1'b1;
            out_last  <= (LAST_CH == '0);
          end
        end
        ST_STREAM: begin
          if (pop) begin
            if (pop_last) begin
              out_ch <= '0;
              if (level_nxt == '0) begin
                state     <= ST_EMPTY;
                out_valid <= 1'b0;
                out_last  <= 1'b0;
              end else begin
                out_last  <= (LAST_CH == '0);
              end
            end else begin
              out_ch   <= out_ch + 1'b1;
              out_last <= ((out_ch + 1'b1) == LAST_CH);
            end
          end
        end
        default: begin
          state     <= ST_EMPTY;
          out_valid <= 1'b0;
          out_last  <= 1'b0;
          out_ch    <= '0;
        end
      endcase
    end
  end

  // Sticky overflow and saturating drop counter; clear beats a same-cycle drop.
  always_ff @(posedge clk) begin
    if (rst || bus.clear_ovf) begin
      overflow <= 1'b0;
      drop_cnt <= '0;
    end else if (drop) begin
      overflow <= 1'b1;
      if (drop_cnt != CNT_MAX) drop_cnt <= drop_cnt + 1'b1;
    end
  end

  adc_frame_ram #(
    .N_CH     (N_CH),
    .SAMPLE_W (SAMPLE_W),
    .DEPTH    (DEPTH),
    .AW       (AW),
    .CH_W     (CH_W)
  ) u_ram (
    .clk   (clk),
    .we    (wr_en),
    .waddr (wr_ptr),
    .wdata (bus.in_frame),
    .raddr (rd_ptr),
    .rch   (out_ch),
    .rdata (bus.out_data)
  );

  assign bus.out_valid = out_valid;
  assign bus.out_ch    = out_ch;
  assign bus.out_last  = out_last;
  assign bus.level     = level;
  assign bus.overflow  = overflow;
  assign bus.drop_cnt  = drop_cnt;

endmodule

// File: tb/tb_adc_frame_fifo.sv
// Bench for adc_frame_fifo: frame-queue reference model, checked every cycle.
module tb_adc_frame_fifo;
  import adc_pkg::*;

  localparam int DEPTH = FIFO_DEPTH;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  adc_frame_fifo_if #(.N_CH(N_CH), .SAMPLE_W(SAMPLE_W), .DEPTH(DEPTH)) bus();

  adc_frame_fifo #(.N_CH(N_CH), .SAMPLE_W(SAMPLE_W), .DEPTH(DEPTH)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int n_assert = 0;
  int n_fail   = 0;

  // Reference model: stored frames, position inside the head frame, status.
  adc_frame_t q[$];
  bit         m_valid = 1'b0;
  int         m_ch    = 0;
  bit         m_ovf   = 1'b0;
  int         m_cnt   = 0;

  adc_frame_t zf = '0;

  function automatic adc_frame_t rand_frame();
    adc_frame_t f;
    for (int c = 0; c < N_CH; c++) f[c] = $urandom;
    return f;
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_outputs(input string tag);
    chk({tag, ":out_valid"}, 64'(bus.out_valid), 64'(m_valid));
    chk({tag, ":level"},     64'(bus.level),     64'(q.size()));
    chk({tag, ":overflow"},  64'(bus.overflow),  64'(m_ovf));
    chk({tag, ":drop_cnt"},  64'(bus.drop_cnt),  64'(m_cnt));
    if (m_valid) begin
      chk({tag, ":out_data"}, 64'(bus.out_data), 64'(q[0][m_ch]));
      chk({tag, ":out_ch"},   64'(bus.out_ch),   64'(m_ch));
      chk({tag, ":out_last"}, 64'(bus.out_last), 64'(m_ch == N_CH - 1));
    end else begin
      chk({tag, ":out_last"}, 64'(bus.out_last), 64'd0);
    end
  endtask

  // One clock: drive inputs, advance the model by the same rules, check.
  task automatic step(input string tag, input bit iv, input adc_frame_t f,
                      input bit rdy, input bit clr);
    bit pop, pop_last, acc;
    int qb;
    bus.in_valid  = iv;
    bus.in_frame  = f;
    bus.out_ready = rdy;
    bus.clear_ovf = clr;
    pop      = m_valid && rdy;
    pop_last = pop && (m_ch == N_CH - 1);
    acc      = iv && ((q.size() < DEPTH) || pop_last);
    qb       = q.size();
    if (pop) begin
      if (pop_last) begin
        void'(q.pop_front());
        m_ch = 0;
      end else begin
        m_ch++;
      end
    end
    if (acc) q.push_back(f);
    // A word is presented once a frame has been stored for a full cycle,
    // or immediately when the previous frame's stream rolls straight over.
    m_valid = (q.size() > 0) && (m_valid || qb > 0);
    if (clr) begin
      m_ovf = 1'b0;
      m_cnt = 0;
    end else if (iv && !acc) begin
      m_ovf = 1'b1;
      if (m_cnt < 65535) m_cnt++;
    end
    @(posedge clk);
    #1;
    check_outputs(tag);
  endtask

  task automatic do_reset(input string tag);
    rst           = 1'b1;
    bus.in_valid  = 1'b1;          // must be ignored during reset
    bus.in_frame  = rand_frame();
    bus.out_ready = 1'b1;
    bus.clear_ovf = 1'b0;
    @(posedge clk);
    #1;
    rst          = 1'b0;
    bus.in_valid = 1'b0;
    q.delete();
    m_valid = 1'b0;
    m_ch    = 0;
    m_ovf   = 1'b0;
    m_cnt   = 0;
    check_outputs(tag);
  endtask

  task automatic drain(input string tag);
    for (int i = 0; i < 200 && (q.size() > 0 || m_valid); i++) step(tag, 1'b0, zf, 1'b1, 1'b0);
    chk({tag, ":drained_level"}, 64'(bus.level), 64'd0);
    chk({tag, ":drained_valid"}, 64'(bus.out_valid), 64'd0);
  endtask

  initial begin
    adc_frame_t fa;
    int sent;

    bus.in_valid  = 1'b0;
    bus.in_frame  = '0;
    bus.out_ready = 1'b0;
    bus.clear_ovf = 1'b0;
    @(posedge clk);
    #1;
    do_reset("reset");
    chk("reset:level_zero", 64'(bus.level), 64'd0);

    // Single frame, ready high, extreme bit patterns pass untouched.
    fa = {32'h7FFF_FFFF, 32'h0000_0001, 32'hFFFF_FFFF, 32'h8000_0000};
    step("one_wr", 1'b1, fa, 1'b1, 1'b0);
    chk("one_wr:level1", 64'(bus.level), 64'd1);
    chk("one_wr:no_valid_yet", 64'(bus.out_valid), 64'd0);
    step("one_w0", 1'b0, zf, 1'b1, 1'b0);
    chk("one_w0:A0", 64'(bus.out_data), 64'h8000_0000);
    step("one_w1", 1'b0, zf, 1'b1, 1'b0);
    chk("one_w1:A1", 64'(bus.out_data), 64'hFFFF_FFFF);
    step("one_w2", 1'b0, zf, 1'b1, 1'b0);
    step("one_w3", 1'b0, zf, 1'b1, 1'b0);
    chk("one_w3:A3", 64'(bus.out_data), 64'h7FFF_FFFF);
    chk("one_w3:last", 64'(bus.out_last), 64'd1);
    step("one_done", 1'b0, zf, 1'b1, 1'b0);
    chk("one_done:level0", 64'(bus.level), 64'd0);

    // Fill with ready low, ninth frame dropped, then drain in order.
    do_reset("ovf_rst");
    for (int i = 0; i < DEPTH; i++) step("ovf_fill", 1'b1, rand_frame(), 1'b0, 1'b0);
    step("ovf_9th", 1'b1, rand_frame(), 1'b0, 1'b0);
    chk("ovf_9th:level8", 64'(bus.level), 64'(DEPTH));
    chk("ovf_9th:ovf", 64'(bus.overflow), 64'd1);
    chk("ovf_9th:cnt1", 64'(bus.drop_cnt), 64'd1);
    drain("ovf_drain");

    // Full FIFO, ninth frame coincides with the last word leaving.
    do_reset("full_rst");
    for (int i = 0; i < DEPTH; i++) step("full_fill", 1'b1, rand_frame(), 1'b0, 1'b0);
    for (int i = 0; i < N_CH - 1; i++) step("full_pop", 1'b0, zf, 1'b1, 1'b0);
    step("full_swap", 1'b1, rand_frame(), 1'b1, 1'b0);
    chk("full_swap:level8", 64'(bus.level), 64'(DEPTH));
    chk("full_swap:no_ovf", 64'(bus.overflow), 64'd0);
    chk("full_swap:ch0", 64'(bus.out_ch), 64'd0);
    drain("full_drain");

    // 100 random frames with random downstream stalls.
    do_reset("rnd_rst");
    sent = 0;
    for (int i = 0; i < 5000 && sent < 100; i++) begin
      bit iv;
      iv = ($urandom_range(0, 11) == 0);
      if (iv) sent++;
      step("rnd", iv, rand_frame(), bit'($urandom_range(0, 1)), 1'b0);
    end
    chk("rnd:all_sent", 64'(sent), 64'd100);
    drain("rnd_drain");
    chk("rnd:no_drops", 64'(bus.drop_cnt), 64'd0);

    // Reset in the middle of a frame with three frames stored.
    do_reset("mid_rst0");
    for (int i = 0; i < 3; i++) step("mid_fill", 1'b1, rand_frame(), 1'b0, 1'b0);
    step("mid_pop0", 1'b0, zf, 1'b1, 1'b0);
    step("mid_pop1", 1'b0, zf, 1'b1, 1'b0);
    chk("mid_pop1:ch2", 64'(bus.out_ch), 64'd2);
    do_reset("mid_rst");
    chk("mid_rst:valid0", 64'(bus.out_valid), 64'd0);
    chk("mid_rst:level0", 64'(bus.level), 64'd0);
    step("mid_new", 1'b1, rand_frame(), 1'b0, 1'b0);
    step("mid_show", 1'b0, zf, 1'b0, 1'b0);
    chk("mid_show:ch0", 64'(bus.out_ch), 64'd0);
    drain("mid_drain");

    // Drop counter saturation, then clear with a coincident drop.
    do_reset("sat_rst");
    for (int i = 0; i < DEPTH; i++) step("sat_fill", 1'b1, rand_frame(), 1'b0, 1'b0);
    for (int i = 0; i < 65535; i++) step("sat_drop", 1'b1, zf, 1'b0, 1'b0);
    chk("sat:cnt_max", 64'(bus.drop_cnt), 64'hFFFF);
    step("sat_more", 1'b1, zf, 1'b0, 1'b0);
    chk("sat_more:held", 64'(bus.drop_cnt), 64'hFFFF);
    step("sat_clr", 1'b1, zf, 1'b0, 1'b1);
    chk("sat_clr:cnt0", 64'(bus.drop_cnt), 64'd0);
    chk("sat_clr:ovf0", 64'(bus.overflow), 64'd0);
    drain("sat_drain");

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
